// File: rtl/fifo_rr_arbiter_if.sv
// FIFO handshake bundle shared by the round-robin arbiter and its FIFOs.
// The master side is the arbiter: it pops the four input FIFOs and pushes the output FIFO.
interface fifo_rr_arbiter_if #(
    parameter int unsigned FIFO_DATA_WIDTH = 32
);
    logic [3:0]                   fifo_in_rd_en;
    logic [4*FIFO_DATA_WIDTH-1:0] fifo_in_dout;
    logic [3:0]                   fifo_in_empty;
    logic                         fifo_out_wr_en;
    logic [FIFO_DATA_WIDTH+1:0]   fifo_out_din;
    logic                         fifo_out_full;

    modport master (
        output fifo_in_rd_en,
        input  fifo_in_dout,
        input  fifo_in_empty,
        output fifo_out_wr_en,
        output fifo_out_din,
        input  fifo_out_full
    );

    modport slave (
        input  fifo_in_rd_en,
        output fifo_in_dout,
        output fifo_in_empty,
        input  fifo_out_wr_en,
        input  fifo_out_din,
        output fifo_out_full
    );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// Four-input round-robin arbiter feeding one shared output FIFO.
// Each word is tagged with its 2-bit source port; a granted port keeps
// the grant for up to BURST_LEN consecutive words.
module fifo_rr_arbiter #(
    parameter int unsigned FIFO_DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN       = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    fifo_rr_arbiter_if.master         bus,
    output logic [1:0]                grant,
    output logic                      busy
);

    typedef enum logic [1:0] {
        S_ARB   = 2'd0,
        S_WRITE = 2'd1
    } state_t;

    state_t                     state;
    logic [FIFO_DATA_WIDTH-1:0] data;
    logic [1:0]                 tag;
    logic [1:0]                 last;
    logic [7:0]                 burst_cnt;

    logic [FIFO_DATA_WIDTH-1:0] words [4];
    logic [1:0]                 sel;
    logic [1:0]                 cand;
    logic                       found;
    logic                       burst_more;

    // Split the packed input bus into per-port words.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            words[i] = bus.fifo_in_dout[i*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];
        end
    end

    // Scan last+1, last+2, last+3, last and pick the first non-empty port.
    always_comb begin
        sel   = 2'd0;
        cand  = 2'd0;
        found = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) begin
            cand = last + 2'(i);
            if (!found && !bus.fifo_in_empty[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    // Burst may continue while under the length limit and the granted port has data.
    always_comb begin
        burst_more = (burst_cnt < 8'(BURST_LEN)) && !bus.fifo_in_empty[tag];
    end

    // Strobes are masked while reset is asserted so nothing is popped or pushed asynchronously.
    always_comb begin
        bus.fifo_in_rd_en  = '0;
        bus.fifo_out_wr_en = 1'b0;
        bus.fifo_out_din   = {tag, data};
        grant              = last;
        busy               = (state == S_WRITE);
        if (reset) begin
            case (state)
                S_ARB: begin
                    if (found) begin
                        bus.fifo_in_rd_en[sel] = 1'b1;
                    end
                end
                S_WRITE: begin
                    if (!bus.fifo_out_full) begin
                        bus.fifo_out_wr_en = 1'b1;
                        if (burst_more) begin
                            bus.fifo_in_rd_en[tag] = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Arbitration / burst state machine and the single-word holding register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_ARB;
            data      <= '0;
            tag       <= 2'd0;
            last      <= 2'd3;
            burst_cnt <= '0;
        end else begin
            case (state)
                S_ARB: begin
                    if (found) begin
                        data      <= words[sel];
                        tag       <= sel;
                        last      <= sel;
                        burst_cnt <= 8'd1;
                        state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (!bus.fifo_out_full) begin
                        if (burst_more) begin
                            data      <= words[tag];
                            burst_cnt <= burst_cnt + 8'd1;
                        end else begin
                            state <= S_ARB;
                        end
                    end
                end
                default: begin
                    state <= S_ARB;
                end
            endcase
        end
    end

endmodule

// File: doc/fifo_rr_arbiter.md
# fifo_rr_arbiter

Four-input round-robin arbiter that shares one output FIFO between four streaming input FIFOs. It pops words from whichever input FIFOs are non-empty and pushes them into the single output FIFO, tagging each word with its 2-bit source index. A granted source keeps the grant for a burst of up to BURST_LEN words. The block sits between per-channel producer FIFOs and a shared downstream consumer, and uses the same rd_en/dout/empty and wr_en/din/full FIFO handshakes as the other streaming blocks.

## Interface
- FIFO_DATA_WIDTH, 32, payload width of each input FIFO word
- BURST_LEN, 4, maximum consecutive words taken from one granted port; legal range 1..255
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- fifo_in_rd_en  output  4  per-port pop strobe; bit i pops input FIFO i
- fifo_in_dout  input  4*FIFO_DATA_WIDTH  port i data in bits [i*W +: W]; first-word-fall-through, valid whenever empty[i]=0
- fifo_in_empty  input  4  per-port empty flag
- fifo_out_wr_en  output  1  push strobe to the output FIFO
- fifo_out_din  output  FIFO_DATA_WIDTH+2  {tag[1:0], data}; tag is the source port index
- fifo_out_full  input  1  output FIFO full flag
- grant  output  2  currently or last granted port
- busy  output  1  1 while in S_WRITE

## Operation
- Registers: state, data[W-1:0], tag[1:0], last[1:0], burst_cnt[7:0].
- Outputs are combinational from the registers and inputs. Defaults: rd_en=0, wr_en=0, fifo_out_din={tag,data}, grant=last, busy=(state==S_WRITE).
- S_ARB:
  - If all ports are empty, stay in S_ARB.
  - Otherwise, select the first non-empty port scanning last+1, last+2, last+3, last (mod 4).
  - Assert rd_en[sel] for that cycle.
  - On the clock edge: data<=dout[sel], tag<=sel, last<=sel, burst_cnt<=1, then go to S_WRITE.
- S_WRITE with full=1: assert nothing and hold all registers.
- S_WRITE with full=0: assert wr_en.
  - If burst_cnt<BURST_LEN and empty[tag]=0: also assert rd_en[tag] in the same cycle. On the clock edge, data<=dout[tag] and burst_cnt<=burst_cnt+1. Stay in S_WRITE.
  - Otherwise go to S_ARB.
- Invalid state encoding goes to S_ARB.
- Only one bit of rd_en is ever asserted. rd_en is never asserted for an empty port, and wr_en is never asserted while full=1.
- Fairness: after a burst ends, the port just served has the lowest priority in the next scan.
- Words are never dropped or duplicated during normal operation. Per-port order is preserved.

## Timing
- Reset (reset=0, asynchronous): state=S_ARB, data=0, tag=0, last=3 (so the first scan starts at port 0), burst_cnt=0.
  - Output values during reset: rd_en=0, wr_en=0, fifo_out_din=0, grant=3, busy=0.
- Latency: a word popped in S_ARB in cycle N is written in cycle N+1 at the earliest.
- Throughput within a burst: 1 word per cycle. Each arbitration costs one bubble cycle with wr_en=0.
- Full during a burst: the pending word is held stable on fifo_out_din until full drops. No pop occurs while stalled.
- Input goes empty mid-burst: the last captured word is written, then the block returns to S_ARB. The burst ends early.
- BURST_LEN=1: every write is followed by S_ARB, giving strict word-by-word round-robin.
- Simultaneous requests from all ports: grants rotate 0,1,2,3,0,… starting at port 0 after reset.
- Reset asserted while in S_WRITE: the captured word is discarded. It was already popped, so it is lost. This is accepted behaviour.

## Test plan
- Single source: port 2 holds 3 words (A,B,C), BURST_LEN=4, full=0 -> rd_en=4'b0100 in cycle 0. Output words {2,A},{2,B},{2,C} appear in cycles 1-3 with wr_en=1. The block returns to S_ARB in cycle 4.
- All four ports hold 8 words each, BURST_LEN=4 -> tags in output order are 0×4, 1×4, 2×4, 3×4, 0×4, 1×4, 2×4, 3×4. There is one wr_en=0 bubble between bursts, and 32 words in total.
- Backpressure: full=1 for 5 cycles mid-burst on port 1 -> wr_en=0 and rd_en=0 throughout the stall, and fifo_out_din stays constant. Resuming does not lose or duplicate any word.
- BURST_LEN=1: ports 0 and 3 are always non-empty -> tags alternate 0,3,0,3. Each write is separated by one S_ARB cycle.
- Reset: drive reset=0 asynchronously mid-burst -> rd_en, wr_en, busy and fifo_out_din go to 0 and grant goes to 3 immediately, without waiting for a clock edge. After release, the first grant goes to the lowest-index non-empty port.
